// File: rtl/btb.sv
// btb: direct-mapped branch target buffer for the fetch stage.
// Lookup is combinational from lookup_pc; training comes from the execute
// stage's resolved control flow and takes effect on the next rising edge.
// Optional feature macro: BTB_2BIT_CTR_EN. When defined, each entry keeps a
// 2-bit saturating direction counter; otherwise a single last-outcome bit.
module btb #(
  parameter int ENTRIES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        btb_hit,
  output logic        predicted_taken,
  output logic [31:0] predicted_next_pc,
  input  logic        update_btb,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_jump_addr,
  input  logic        ex_taken
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;

`ifdef BTB_2BIT_CTR_EN
  localparam int CW = 2;
  localparam logic [CW-1:0] CTR_RST   = 2'b01;
  localparam logic [CW-1:0] CTR_ALLOC = 2'b10;
  localparam logic [CW-1:0] CTR_MAX   = 2'b11;
  localparam logic [CW-1:0] CTR_MIN   = 2'b00;
`else
  localparam int CW = 1;
  localparam logic [CW-1:0] CTR_RST   = 1'b0;
  localparam logic [CW-1:0] CTR_ALLOC = 1'b1;
`endif

  // Per-entry state
  logic          valid_q  [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];
  logic [CW-1:0] ctr_q    [ENTRIES];

  // Address split for the fetch-side lookup and the execute-side update
  logic [IDX-1:0] lk_idx;
  logic [TW-1:0]  lk_tag;
  logic [IDX-1:0] ex_idx;
  logic [TW-1:0]  ex_tag;
  logic           ex_hit;
  logic [CW-1:0]  ctr_next;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[31:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[31:IDX+2];

  // Byte-offset bits of the execute PC play no part in indexing or tagging.
  logic unused_ex_pc_bits;
  assign unused_ex_pc_bits = ^ex_pc[1:0];

  // Combinational lookup: hit, direction and next fetch PC (pre-update state)
  always_comb begin
    btb_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predicted_taken   = btb_hit && ctr_q[lk_idx][CW-1];
    predicted_next_pc = predicted_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
  end

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Direction state after a resolved outcome on a hitting entry
  always_comb begin
    // NOTE: assign a default first so every path drives ctr_next; otherwise a latch is inferred.
    ctr_next = ctr_q[ex_idx];
`ifdef BTB_2BIT_CTR_EN
    if (ex_taken && (ctr_q[ex_idx] != CTR_MAX)) begin
      ctr_next = ctr_q[ex_idx] + 2'd1;
    end else if (!ex_taken && (ctr_q[ex_idx] != CTR_MIN)) begin
      ctr_next = ctr_q[ex_idx] - 2'd1;
    end
`else
    ctr_next = ex_taken;
`endif
  end

  // Entry storage: synchronous reset clears all history; reset beats update
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole table is reset because stale targets/counters must not
      // survive a reset; this keeps the arrays in flops rather than RAM macros.
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: non-blocking assignments for all sequential state so every
        // reader in this cycle sees the pre-edge contents.
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
    end else if (update_btb) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_next;
        if (ex_taken) begin
          target_q[ex_idx] <= ex_jump_addr;
        end
      end else if (ex_taken) begin
        // Allocate, evicting whatever aliased at this index
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_jump_addr;
        ctr_q[ex_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: doc/btb.md
# btb

Direct-mapped branch target buffer in the fetch stage. Each cycle it predicts the next fetch PC from the current fetch PC. It is trained by the execute stage's resolved control-flow outcome, using `update_btb`, the resolved target address and the actual taken decision. Its `predicted_taken` output travels down the pipeline as the `predictedTaken` that execute compares against the real outcome to decide a redirect.

## Interface
- `ENTRIES`, default 32: number of BTB entries. Must be a power of two, ≥ 2. IDX = log2(ENTRIES); tag width TW = 30 − IDX.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lookup_pc`  in  32  current fetch PC.
- `btb_hit`  out  1  the entry at `lookup_pc`'s index is valid and its tag matches.
- `predicted_taken`  out  1  prediction for the instruction at `lookup_pc`.
- `predicted_next_pc`  out  32  next fetch PC.
- `update_btb`  in  1  execute holds a resolved branch or jump this cycle.
- `ex_pc`  in  32  PC of the resolved instruction.
- `ex_jump_addr`  in  32  resolved target address.
- `ex_taken`  in  1  actual outcome: 1 for jumps; the branch condition result for branches.

## Operation
- Address split:
  - index = pc[IDX+1:2];
  - tag = pc[31:IDX+2];
  - pc[1:0] ignored.
- Per-entry state: `valid`, `tag`[TW], `target`[32], `ctr`[2].
- Lookup (combinational):
  - `btb_hit` = valid[i] && tag[i] == tag(lookup_pc).
  - `predicted_taken` = `btb_hit` && ctr[i][1].
  - `predicted_next_pc` = `predicted_taken` ? target[i] : lookup_pc + 4, with modulo-2^32 wrap (0xFFFFFFFC → 0x00000000).
- Update, on an edge where `update_btb` = 1, at index j of `ex_pc`:
  - Hit, `ex_taken` = 1: ctr saturating-increments (max 2'b11); target ← `ex_jump_addr`.
  - Hit, `ex_taken` = 0: ctr saturating-decrements (min 2'b00); target and valid unchanged.
  - Miss (invalid entry or tag mismatch), `ex_taken` = 1: allocate. Set valid ← 1, tag ← tag(`ex_pc`), target ← `ex_jump_addr`, ctr ← 2'b10. Any aliasing entry is evicted.
  - Miss, `ex_taken` = 0: no change. Never allocate on not-taken.
- Entries are never invalidated except by reset.

## Timing
- Lookup latency: 0 cycles (purely combinational from `lookup_pc` and state).
- An update written at edge N is visible to lookups from cycle N+1.
- Same cycle, same index: lookup returns the pre-update contents. No write-to-read bypass.
- `rst` = 1 at an edge:
  - all valid ← 0, all ctr ← 2'b01, targets ← 0;
  - `rst` has priority over a simultaneous `update_btb`, whose update is discarded.
- Outputs during and after reset, until the first allocation: `btb_hit` = 0, `predicted_taken` = 0, `predicted_next_pc` = lookup_pc + 4.
- A reset applied mid-operation loses all history; no partial entries remain.
- Updates may arrive every cycle, one per cycle. Back-to-back updates to the same index see the state produced by the previous edge.

## Configuration
- `BTB_2BIT_CTR_EN` defined: ctr is a 2-bit saturating counter as described above; prediction uses ctr[1].
- Not defined: ctr is a single last-outcome bit.
  - Hit: bit ← `ex_taken`.
  - Allocate: bit ← 1.
  - Reset: bit ← 0.
  - Prediction: `btb_hit` && bit.
  - Target update rules unchanged.
- The interface is identical in both builds.

## Test plan
All scenarios use `ENTRIES` = 32.
- Reset, then lookup 0x00000100 → `btb_hit` = 0, `predicted_taken` = 0, `predicted_next_pc` = 0x00000104.
- Update `ex_pc` = 0x100, `ex_jump_addr` = 0x200, `ex_taken` = 1; next cycle lookup 0x100 → hit 1, taken 1, next 0x200. Lookup 0x180 (same index, different tag) → hit 0, next 0x184.
- With `BTB_2BIT_CTR_EN`, from the allocated entry (ctr 10):
  - one not-taken update → ctr 01, prediction 0, `btb_hit` still 1;
  - a second → 00;
  - three taken updates → 01, 10, 11;
  - a further taken update → stays 11.
- Without the macro: allocate, then one not-taken update → prediction 0. A following taken update to 0x300 → prediction 1, next 0x300.
- In the same cycle, update 0x100 → 0x400 taken and lookup 0x100 → output is the old target 0x200. The following cycle → 0x400.
- `rst` and `update_btb` asserted together at an edge for `ex_pc` 0x100 → the entry stays invalid; the next lookup 0x100 → hit 0, next 0x104.
- Lookup 0xFFFFFFFC after reset → `predicted_next_pc` = 0x00000000.
